// File: rtl/reg_writeback_arbiter_if.sv
// Write-back arbiter bus: pipeline and MDU write requests, register file
// write port, ID-stage bypass lookup and FIFO occupancy.
//
// Handshake: the pipeline request (pipe_wr_en) has no ready and is always
// taken. The MDU result transfers on the posedge where mdu_valid && mdu_ready;
// the master holds mdu_reg/mdu_data stable while mdu_valid is high and not yet
// accepted. mdu_ready depends only on registered occupancy.
interface reg_writeback_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              pipe_wr_en;
  logic [4:0]        pipe_wr_reg;
  logic [DATA_W-1:0] pipe_wr_data;
  logic              mdu_valid;
  logic [4:0]        mdu_reg;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              rf_reg_write;
  logic [4:0]        rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [4:0]        byp_reg1;
  logic [4:0]        byp_reg2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
  logic [CW-1:0]     pending;

  modport master (
    output pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    output mdu_valid, mdu_reg, mdu_data,
    output byp_reg1, byp_reg2,
    input  mdu_ready, rf_reg_write, rf_write_reg, rf_write_data,
    input  byp_hit1, byp_hit2, byp_data1, byp_data2, pending
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    input  mdu_valid, mdu_reg, mdu_data,
    input  byp_reg1, byp_reg2,
    output mdu_ready, rf_reg_write, rf_write_reg, rf_write_data,
    output byp_hit1, byp_hit2, byp_data1, byp_data2, pending
  );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-back arbiter. One write per cycle goes to the register
// file; anything that cannot issue waits in a small in-order FIFO. The FIFO
// head always wins so writes leave in program order. Only the MDU can grow
// the FIFO, so throttling mdu_ready keeps it from overflowing.
module reg_writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  reg_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]        mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, wr_ptr_p1;
  logic [CW-1:0]     count_q, count_d, enq_cnt;
  logic              rf_we_q;
  logic [4:0]        rf_reg_q;
  logic [DATA_W-1:0] rf_data_q;

  logic              fifo_ne, pipe_v, mdu_v, pipe_enq, mdu_enq;
  logic              enq0_v, enq1_v;
  logic [4:0]        enq0_reg;
  logic [DATA_W-1:0] enq0_data;
  logic              iss_v;
  logic [4:0]        iss_reg;
  logic [DATA_W-1:0] iss_data;

  // Room for two new entries guarantees the MDU can always be absorbed.
  assign bus.mdu_ready = (count_q <= CW'(DEPTH - 2));

  // Writes to r0 are discarded here; the MDU handshake still completes.
  assign fifo_ne  = (count_q != '0);
  assign pipe_v   = bus.pipe_wr_en && (bus.pipe_wr_reg != 5'd0);
  assign mdu_v    = bus.mdu_valid && bus.mdu_ready && (bus.mdu_reg != 5'd0);
  assign pipe_enq = pipe_v && fifo_ne;
  assign mdu_enq  = mdu_v && (fifo_ne || pipe_v);

  // Pipeline is older than a same-cycle MDU result, so it takes slot 0.
  assign enq0_v    = pipe_enq || mdu_enq;
  assign enq1_v    = pipe_enq && mdu_enq;
  assign enq0_reg  = pipe_enq ? bus.pipe_wr_reg : bus.mdu_reg;
  assign enq0_data = pipe_enq ? bus.pipe_wr_data : bus.mdu_data;
  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign enq_cnt   = {{(CW-1){1'b0}}, pipe_enq} + {{(CW-1){1'b0}}, mdu_enq};
  assign count_d   = count_q + enq_cnt - {{(CW-1){1'b0}}, fifo_ne};

  // Select this cycle's write: FIFO head, then pipeline, then MDU.
  always_comb begin
    iss_v    = 1'b0;
    iss_reg  = '0;
    iss_data = '0;
    if (fifo_ne) begin
      iss_v    = 1'b1;
      iss_reg  = mem_reg_q[rd_ptr_q];
      iss_data = mem_data_q[rd_ptr_q];
    end else if (pipe_v) begin
      iss_v    = 1'b1;
      iss_reg  = bus.pipe_wr_reg;
      iss_data = bus.pipe_wr_data;
    end else if (mdu_v) begin
      iss_v    = 1'b1;
      iss_reg  = bus.mdu_reg;
      iss_data = bus.mdu_data;
    end
  end

  // Register file write stage; address/data hold when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= iss_v;
      if (iss_v) begin
        rf_reg_q  <= iss_reg;
        rf_data_q <= iss_data;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + enq_cnt[PW-1:0];
      rd_ptr_q <= rd_ptr_q + PW'(fifo_ne);
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq0_v) begin
      mem_reg_q[wr_ptr_q]  <= enq0_reg;
      mem_data_q[wr_ptr_q] <= enq0_data;
    end
    if (enq1_v) begin
      mem_reg_q[wr_ptr_p1]  <= bus.mdu_reg;
      mem_data_q[wr_ptr_p1] <= bus.mdu_data;
    end
  end

  // Youngest pending value for r: rf stage, then FIFO oldest to newest,
  // with later matches overriding earlier ones. Result is {hit, data}.
  function automatic logic [DATA_W:0] lookup(input logic [4:0] r);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    if (r != 5'd0) begin
      if (rf_we_q && (rf_reg_q == r)) res = {1'b1, rf_data_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (mem_reg_q[idx] == r))
          res = {1'b1, mem_data_q[idx]};
      end
    end
    return res;
  endfunction

  // Combinational bypass for both ID-stage read ports.
  always_comb begin
    {bus.byp_hit1, bus.byp_data1} = lookup(bus.byp_reg1);
    {bus.byp_hit2, bus.byp_data2} = lookup(bus.byp_reg2);
  end

  assign bus.rf_reg_write  = rf_we_q;
  assign bus.rf_write_reg  = rf_reg_q;
  assign bus.rf_write_data = rf_data_q;
  assign bus.pending       = count_q;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter (DEPTH=4, DATA_W=32).
module tb_reg_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  reg_writeback_arbiter_if #(.DEPTH(4), .DATA_W(32)) bus ();

  reg_writeback_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_wr_en   = 1'b0;
    bus.pipe_wr_reg  = '0;
    bus.pipe_wr_data = '0;
    bus.mdu_valid    = 1'b0;
    bus.mdu_reg      = '0;
    bus.mdu_data     = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.byp_reg1 = 5'd5;
    bus.byp_reg2 = 5'd0;
    #2;
    n_chk++; if (bus.pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", bus.pending); end
    n_chk++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", bus.rf_reg_write); end
    n_chk++; if (bus.rf_write_reg !== 5'd0 || bus.rf_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_rf: got %0d/%0h expected 0/0", bus.rf_write_reg, bus.rf_write_data); end
    n_chk++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", bus.mdu_ready); end
    n_chk++; if (bus.byp_hit1 !== 1'b0 || bus.byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_byp: got %0b%0b expected 00", bus.byp_hit1, bus.byp_hit2); end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_chk++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL post_reset_we: got %0b expected 0", bus.rf_reg_write); end
  endtask

  task automatic test_single_pipe();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'd5; bus.pipe_wr_data = 32'hAAAA0005;
    tick(); idle();
    n_chk++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_reg !== 5'd5 || bus.rf_write_data !== 32'hAAAA0005)
      begin n_fail++; $display("FAIL single_pipe: got %0b/%0d/%0h expected 1/5/aaaa0005", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data); end
    n_chk++; if (bus.pending !== 3'd0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", bus.pending); end
    tick();
    n_chk++; if (bus.rf_reg_write !== 1'b0 || bus.rf_write_reg !== 5'd5 || bus.rf_write_data !== 32'hAAAA0005)
      begin n_fail++; $display("FAIL single_hold: got %0b/%0d/%0h expected 0/5/aaaa0005", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data); end
  endtask

  task automatic test_pipe_mdu_same();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'd3; bus.pipe_wr_data = 32'h33;
    bus.mdu_valid  = 1'b1; bus.mdu_reg     = 5'd4; bus.mdu_data     = 32'h44;
    #1;
    n_chk++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready0: got %0b expected 1", bus.mdu_ready); end
    tick(); idle();
    n_chk++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_reg !== 5'd3 || bus.rf_write_data !== 32'h33)
      begin n_fail++; $display("FAIL same_c1: got %0b/%0d/%0h expected 1/3/33", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data); end
    n_chk++; if (bus.pending !== 3'd1 || bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL same_c1_pend: got %0d/%0b expected 1/1", bus.pending, bus.mdu_ready); end
    tick();
    n_chk++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_reg !== 5'd4 || bus.rf_write_data !== 32'h44)
      begin n_fail++; $display("FAIL same_c2: got %0b/%0d/%0h expected 1/4/44", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data); end
    n_chk++; if (bus.pending !== 3'd0 || bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL same_c2_pend: got %0d/%0b expected 0/1", bus.pending, bus.mdu_ready); end
    tick();
    n_chk++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL same_c3: got %0b expected 0", bus.rf_reg_write); end
  endtask

  // Pipe r9..r13 on five cycles, MDU r21..r24 offered continuously.
  task automatic test_fill();
    logic [4:0] exp_reg   [10] = '{5'd9, 5'd21, 5'd10, 5'd22, 5'd11, 5'd23, 5'd12, 5'd13, 5'd24, 5'd24};
    logic [2:0] exp_pend  [10] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0};
    logic       exp_ready [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_we    [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int  mn = 0;
    logic acc;
    for (int c = 0; c < 10; c++) begin
      bus.pipe_wr_en   = (c < 5);
      bus.pipe_wr_reg  = 5'(9 + c);
      bus.pipe_wr_data = 32'h1000_0000 + 32'(9 + c);
      bus.mdu_valid    = (mn < 4);
      bus.mdu_reg      = 5'(21 + mn);
      bus.mdu_data     = 32'h1000_0000 + 32'(21 + mn);
      #1;
      n_chk++; if (bus.mdu_ready !== exp_ready[c]) begin n_fail++; $display("FAIL fill_ready c%0d: got %0b expected %0b", c, bus.mdu_ready, exp_ready[c]); end
      acc = bus.mdu_valid && bus.mdu_ready;
      tick();
      if (acc) mn++;
      n_chk++; if (bus.rf_reg_write !== exp_we[c] || bus.rf_write_reg !== exp_reg[c] || bus.rf_write_data !== 32'h1000_0000 + 32'(exp_reg[c]))
        begin n_fail++; $display("FAIL fill_issue c%0d: got %0b/%0d/%0h expected %0b/%0d", c, bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data, exp_we[c], exp_reg[c]); end
      n_chk++; if (bus.pending !== exp_pend[c]) begin n_fail++; $display("FAIL fill_pending c%0d: got %0d expected %0d", c, bus.pending, exp_pend[c]); end
    end
    idle();
  endtask

  task automatic test_bypass();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'd1; bus.pipe_wr_data = 32'h11;
    bus.mdu_valid  = 1'b1; bus.mdu_reg     = 5'd2; bus.mdu_data     = 32'h22;
    tick();
    bus.pipe_wr_reg = 5'd7; bus.pipe_wr_data = 32'h1;
    bus.mdu_reg     = 5'd7; bus.mdu_data     = 32'h2;
    tick(); idle();
    bus.byp_reg1 = 5'd7; bus.byp_reg2 = 5'd0; #1;
    n_chk++; if (bus.pending !== 3'd2) begin n_fail++; $display("FAIL byp_pending: got %0d expected 2", bus.pending); end
    n_chk++; if (bus.byp_hit1 !== 1'b1 || bus.byp_data1 !== 32'h2) begin n_fail++; $display("FAIL byp_r7_young: got %0b/%0h expected 1/2", bus.byp_hit1, bus.byp_data1); end
    n_chk++; if (bus.byp_hit2 !== 1'b0 || bus.byp_data2 !== 32'h0) begin n_fail++; $display("FAIL byp_r0: got %0b/%0h expected 0/0", bus.byp_hit2, bus.byp_data2); end
    bus.byp_reg2 = 5'd2; bus.byp_reg1 = 5'd9; #1;
    n_chk++; if (bus.byp_hit2 !== 1'b1 || bus.byp_data2 !== 32'h22) begin n_fail++; $display("FAIL byp_rf_stage: got %0b/%0h expected 1/22", bus.byp_hit2, bus.byp_data2); end
    n_chk++; if (bus.byp_hit1 !== 1'b0 || bus.byp_data1 !== 32'h0) begin n_fail++; $display("FAIL byp_nomatch: got %0b/%0h expected 0/0", bus.byp_hit1, bus.byp_data1); end
    bus.byp_reg1 = 5'd7;
    tick();
    n_chk++; if (bus.rf_write_reg !== 5'd7 || bus.rf_write_data !== 32'h1) begin n_fail++; $display("FAIL byp_order1: got %0d/%0h expected 7/1", bus.rf_write_reg, bus.rf_write_data); end
    n_chk++; if (bus.byp_data1 !== 32'h2) begin n_fail++; $display("FAIL byp_fifo_over_rf: got %0h expected 2", bus.byp_data1); end
    tick();
    n_chk++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_data !== 32'h2 || bus.pending !== 3'd0)
      begin n_fail++; $display("FAIL byp_order2: got %0b/%0h/%0d expected 1/2/0", bus.rf_reg_write, bus.rf_write_data, bus.pending); end
    n_chk++; if (bus.byp_hit1 !== 1'b1 || bus.byp_data1 !== 32'h2) begin n_fail++; $display("FAIL byp_rf_only: got %0b/%0h expected 1/2", bus.byp_hit1, bus.byp_data1); end
    tick();
    n_chk++; if (bus.byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL byp_drained: got %0b expected 0", bus.byp_hit1); end
    bus.byp_reg1 = 5'd0; bus.byp_reg2 = 5'd0;
  endtask

  task automatic test_reg0();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'd0; bus.pipe_wr_data = 32'hFFFF;
    tick(); idle();
    n_chk++; if (bus.rf_reg_write !== 1'b0 || bus.pending !== 3'd0) begin n_fail++; $display("FAIL r0_pipe: got %0b/%0d expected 0/0", bus.rf_reg_write, bus.pending); end
    n_chk++; if (bus.byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL r0_byp: got %0b expected 0", bus.byp_hit1); end
    bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd0; bus.mdu_data = 32'hFFFF; #1;
    n_chk++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL r0_mdu_ready: got %0b expected 1", bus.mdu_ready); end
    tick(); idle();
    n_chk++; if (bus.rf_reg_write !== 1'b0 || bus.pending !== 3'd0) begin n_fail++; $display("FAIL r0_mdu: got %0b/%0d expected 0/0", bus.rf_reg_write, bus.pending); end
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'd0; bus.pipe_wr_data = 32'hFFFF;
    bus.mdu_valid  = 1'b1; bus.mdu_reg     = 5'd9; bus.mdu_data     = 32'h99;
    tick(); idle();
    n_chk++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_reg !== 5'd9 || bus.rf_write_data !== 32'h99 || bus.pending !== 3'd0)
      begin n_fail++; $display("FAIL r0_pipe_mdu: got %0b/%0d/%0h/%0d expected 1/9/99/0", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data, bus.pending); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'(10 + 2*c); bus.pipe_wr_data = 32'(10 + 2*c);
      bus.mdu_valid  = 1'b1; bus.mdu_reg     = 5'(11 + 2*c); bus.mdu_data     = 32'(11 + 2*c);
      tick();
    end
    idle();
    n_chk++; if (bus.pending !== 3'd3) begin n_fail++; $display("FAIL mid_pending_pre: got %0d expected 3", bus.pending); end
    bus.byp_reg1 = 5'd15;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.pending !== 3'd0 || bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %0d/%0b expected 0/0", bus.pending, bus.rf_reg_write); end
    n_chk++; if (bus.mdu_ready !== 1'b1 || bus.byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL mid_ready_byp: got %0b/%0b expected 1/0", bus.mdu_ready, bus.byp_hit1); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (bus.rf_reg_write !== 1'b0 || bus.pending !== 3'd0) begin n_fail++; $display("FAIL mid_stale c%0d: got %0b/%0d expected 0/0", c, bus.rf_reg_write, bus.pending); end
    end
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_reg = 5'd6; bus.pipe_wr_data = 32'h66;
    tick(); idle();
    n_chk++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_reg !== 5'd6 || bus.rf_write_data !== 32'h66)
      begin n_fail++; $display("FAIL mid_resume: got %0b/%0d/%0h expected 1/6/66", bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data); end
    bus.byp_reg1 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_single_pipe();
    test_pipe_mdu_same();
    test_fill();
    test_bypass();
    test_reg0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_writeback_arbiter.md
REG_WRITEBACK_ARBITER -- requirements
Module: reg_writeback_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, pending-write FIFO entries (power of two, >=2).
REQ-002 Parameter: DATA_W, 32, write data width.
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pipe_wr_en  in  1  main pipeline WB-stage write request; cannot be stalled.
REQ-006 pipe_wr_reg  in  5  pipeline destination register.
REQ-007 pipe_wr_data  in  DATA_W  pipeline write data.
REQ-008 mdu_valid  in  1  multi-cycle mul/div result valid.
REQ-009 mdu_reg  in  5  MDU destination register.
REQ-010 mdu_data  in  DATA_W  MDU result.
REQ-011 mdu_ready  out  1  arbiter accepts MDU result this cycle.
REQ-012 rf_reg_write  out  1  register file write enable (registered).
REQ-013 rf_write_reg  out  5  register file write address (registered).
REQ-014 rf_write_data  out  DATA_W  register file write data (registered).
REQ-015 byp_reg1, byp_reg2  in  5 each  ID-stage read addresses to check against pending writes.
REQ-016 byp_hit1, byp_hit2  out  1 each  pending write to that register exists.
REQ-017 byp_data1, byp_data2  out  DATA_W each  youngest pending data for that register.
REQ-018 pending  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 At most one register file write SHALL be issued per cycle, registered into rf_* at posedge; register file samples on the following negedge.
REQ-020 Issue priority each posedge: FIFO head if FIFO non-empty; else pipeline request; else accepted MDU request; else rf_reg_write=0 (rf_write_reg/rf_write_data hold).
REQ-021 Valid requests not issued in a cycle SHALL be enqueued; when both pipeline and MDU enqueue together, pipeline entry is written first (older).
REQ-022 MDU handshake completes on posedge when mdu_valid && mdu_ready; mdu_ready = (pending <= DEPTH-2), combinational from registered count only.
REQ-023 Pipeline requests SHALL always be accepted; occupancy can never exceed DEPTH by construction (net growth only via MDU).
REQ-024 Requests with destination register 0 SHALL be dropped: never enqueued, never issued; MDU handshake still completes.
REQ-025 pending update: +enqueued count -1 if head issued; both enqueue and dequeue in the same cycle SHALL be supported.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 Bypass (combinational): byp_hitN=1 if byp_regN!=0 and matches any valid FIFO entry or the rf_* stage with rf_reg_write=1; byp_dataN from the youngest match (newest FIFO entry > older entries > rf_* stage).
REQ-028 byp_regN=0 SHALL give byp_hitN=0, byp_dataN=0; no match gives byp_dataN=0.
REQ-029 Program order of writes to the same register SHALL be preserved at the register file port.

Reset
REQ-030 While rst=1: FIFO empty, pointers 0, pending=0, rf_reg_write=0, rf_write_reg=0, rf_write_data=0, mdu_ready=1, byp_hit*=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending writes immediately; no write issues in the cycle after reset release unless a new request arrives.

Verification
REQ-032 Idle, pipe_wr_en=1 reg=5 data=0xAAAA0005 -> next posedge rf_reg_write=1, rf_write_reg=5, rf_write_data=0xAAAA0005, pending=0.
REQ-033 Same cycle pipe (reg 3, 0x33) and MDU (reg 4, 0x44), FIFO empty -> cycle1 writes r3, pending=1; cycle2 writes r4, pending=0; mdu_ready stays 1.
REQ-034 MDU valid every cycle plus pipe every cycle, DEPTH=4 -> pending climbs to 3, mdu_ready drops at pending=3, no entry lost, issue order matches arrival order.
REQ-035 FIFO holds r7=0x1 then r7=0x2, byp_reg1=7 -> byp_hit1=1, byp_data1=0x2; byp_reg2=0 -> byp_hit2=0.
REQ-036 Pipe write to reg 0 data 0xFFFF -> rf_reg_write stays 0, pending stays 0, byp_hit for reg 0 stays 0.
REQ-037 rst pulsed with pending=3 -> pending=0, rf_reg_write=0 asynchronously; no stale writes issued after release.
